if_inst_queue: RTL and testbench
================================

Name: if_inst_queue

Overview:
- Small instruction queue between the fetch stage and the decode stage.
- Accepts the {inst, pc} fetch bundle through the fetch stage's valid/allowin handshake, buffers up to DEPTH entries and presents them in order to decode.
- Discards every buffered entry on any front-end redirect: exception, ertn or taken branch.

Parameters:
- DEPTH, 4, number of entries; power of two, at least 2.
- BUS_W, 64, bundle width; {inst[63:32], pc[31:0]}.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- resetn  input  1  reset; asynchronous and active-low.
- fs2ds_valid  input  1  fetch stage holds a valid bundle.
- fs2ds_bus  input  BUS_W  fetch bundle {inst, pc}.
- iq_allowin  output  1  queue can accept a bundle this cycle; drives the fetch stage's ds_allowin.
- iq2ds_valid  output  1  head entry valid toward decode.
- iq2ds_bus  output  BUS_W  head entry {inst, pc}.
- ds_allowin  input  1  decode accepts the head entry this cycle.
- flush  input  1  redirect (wb_ex | ertn_flush | br_taken); discards queue contents.
- iq_count  output  clog2(DEPTH)+1  current occupancy.

Behaviour:
- Storage: DEPTH x BUS_W entries, with head pointer, tail pointer and count.
- Pointers are clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Reset (resetn=0, asynchronous):
  - head=0, tail=0, count=0.
  - iq2ds_valid=0, iq2ds_bus=0, iq_allowin=1, iq_count=0.
  - Entry contents are don't-care.
- iq_allowin = (count != DEPTH). It depends only on count, with no combinational path from ds_allowin.
- push = fs2ds_valid & iq_allowin & ~flush. On push, write entry[tail] and increment tail.
- pop = iq2ds_valid & ds_allowin & ~flush. On pop, increment head.
- count update:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged, and both pointers advance.
- iq2ds_valid = (count != 0).
- iq2ds_bus = entry[head] when count != 0, else 0.
- Latency: a bundle pushed in cycle N is visible at iq2ds_* in cycle N+1 at the earliest (without the bypass feature).
- Flush:
  - In the flush cycle: push and pop are suppressed; the inbound bundle and the head are both discarded.
  - Next edge: head=tail=0, count=0.
  - Cycle after flush: iq2ds_valid=0 and iq_allowin=1.
- Full (count==DEPTH): iq_allowin=0 and the fetch stage stalls.
  - A pop in the full cycle frees one slot, which becomes usable in the next cycle.
- Empty (count==0): iq2ds_valid=0; ds_allowin is ignored.
- Pushes and pops never corrupt order across pointer wrap-around; FIFO order is strict.
- Flush has priority over every other event. Asserting resetn low mid-operation clears state immediately, without waiting for a clock edge.
- There is no state machine beyond the counter: states EMPTY (count=0), PARTIAL, FULL (count=DEPTH) are derived from count.

Optional Feature:
- Macro: IF_INST_QUEUE_BYPASS_EN.
- When defined, and count==0 & fs2ds_valid & ds_allowin & ~flush:
  - The incoming bundle is passed straight to iq2ds_bus with iq2ds_valid=1 in the same cycle (zero latency).
  - It is not written to storage; pointers and count are unchanged.
- When count==0 & fs2ds_valid & ~ds_allowin, the bundle is pushed normally.
- Without the macro, every bundle goes through storage, giving one cycle minimum latency, and iq2ds_valid is purely a function of count.

Test Plan:
- Reset: hold resetn=0 mid-run with count=3, asynchronously -> iq_count=0, iq2ds_valid=0 and iq_allowin=1 before the next clk edge.
- Fill: ds_allowin=0, push pc 0x1C000000, 0x1C000004, 0x1C000008, 0x1C00000C -> iq_count=4, iq_allowin=0, iq2ds_bus[31:0]=0x1C000000. A fifth fs2ds_valid is not accepted.
- Drain with wrap: from full, ds_allowin=1 for 4 cycles while pushing 0x1C000010 and 0x1C000014 -> outputs in order 0x1C000000 through 0x1C000014 with no loss or duplication across pointer wrap.
- Simultaneous push/pop at count=2 -> count stays 2 and order is preserved.
- Flush at count=3 with fs2ds_valid=1 (pc 0x1C000020) -> pc 0x1C000020 is dropped; next cycle iq_count=0 and iq2ds_valid=0. The next pushed pc 0x1C008000 is the first out.
- Bypass with the macro defined, queue empty, ds_allowin=1, push pc 0x1C000040 -> same cycle iq2ds_valid=1, iq2ds_bus[31:0]=0x1C000040, iq_count stays 0. With the macro undefined, the same stimulus gives iq2ds_valid=1 one cycle later with iq_count=1 for that cycle.

Source files
------------

// File: rtl/if_inst_queue.sv
// Fetch-to-decode instruction queue: DEPTH-entry FIFO of {inst, pc} bundles, emptied on any redirect.
// Optional zero-latency empty-queue bypass under `define IF_INST_QUEUE_BYPASS_EN.
module if_inst_queue #(
  parameter int DEPTH = 4,
  parameter int BUS_W = 64
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       fs2ds_valid,
  input  logic [BUS_W-1:0]           fs2ds_bus,
  output logic                       iq_allowin,
  output logic                       iq2ds_valid,
  output logic [BUS_W-1:0]           iq2ds_bus,
  input  logic                       ds_allowin,
  input  logic                       flush,
  output logic [$clog2(DEPTH):0]     iq_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [BUS_W-1:0] mem [DEPTH];
  logic [AW-1:0]    head, tail;
  logic [CW-1:0]    count;
  logic             empty, full, push, pop, bypass;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

`ifdef IF_INST_QUEUE_BYPASS_EN
  // Empty queue and decode ready: hand the bundle straight through, storage untouched.
  assign bypass = empty & fs2ds_valid & ds_allowin & ~flush;
`else
  assign bypass = 1'b0;
`endif

  assign iq_allowin  = ~full;
  assign push        = fs2ds_valid & ~full & ~flush & ~bypass;
  assign pop         = ~empty & ds_allowin & ~flush;
  assign iq2ds_valid = ~empty | bypass;
  assign iq2ds_bus   = bypass ? fs2ds_bus : (empty ? '0 : mem[head]);
  assign iq_count    = count;

  always_ff @(posedge clk) begin
    if (push) mem[tail] <= fs2ds_bus;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + AW'(1);
      if (pop)  head <= head + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: tb/tb_if_inst_queue.sv
// Directed bench for if_inst_queue: queue-based reference model checked every cycle, plus literal pins.
module tb_if_inst_queue;
  localparam int DEPTH = 4;
  localparam int BUS_W = 64;
`ifdef IF_INST_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             resetn = 1'b0;
  logic             fs2ds_valid = 1'b0;
  logic [BUS_W-1:0] fs2ds_bus = '0;
  logic             iq_allowin;
  logic             iq2ds_valid;
  logic [BUS_W-1:0] iq2ds_bus;
  logic             ds_allowin = 1'b0;
  logic             flush = 1'b0;
  logic [2:0]       iq_count;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  logic [BUS_W-1:0] q[$];

  if_inst_queue #(.DEPTH(DEPTH), .BUS_W(BUS_W)) dut (
    .clk(clk), .resetn(resetn), .fs2ds_valid(fs2ds_valid), .fs2ds_bus(fs2ds_bus),
    .iq_allowin(iq_allowin), .iq2ds_valid(iq2ds_valid), .iq2ds_bus(iq2ds_bus),
    .ds_allowin(ds_allowin), .flush(flush), .iq_count(iq_count)
  );

  always #5 clk = ~clk;

  function automatic logic [BUS_W-1:0] mk(input logic [31:0] pc);
    return {~pc, pc};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue, updated on each rising edge from the rules of the handshake.
  always @(negedge resetn) q.delete();

  always @(posedge clk) begin
    if (resetn) begin
      if (flush) q.delete();
      else begin
        automatic bit byp = BYP && q.size() == 0 && fs2ds_valid && ds_allowin;
        automatic bit pp  = q.size() != 0 && ds_allowin;
        automatic bit ps  = fs2ds_valid && q.size() != DEPTH && !byp;
        if (pp) void'(q.pop_front());
        if (ps) q.push_back(fs2ds_bus);
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      automatic bit byp = BYP && resetn && q.size() == 0 && fs2ds_valid && ds_allowin && !flush;
      automatic logic [BUS_W-1:0] eb = byp ? fs2ds_bus : (q.size() != 0 ? q[0] : '0);
      check("model_count",   64'(iq_count),    64'(q.size()));
      check("model_valid",   64'(iq2ds_valid), 64'(q.size() != 0 || byp));
      check("model_allowin", 64'(iq_allowin),  64'(q.size() != DEPTH));
      check("model_bus",     iq2ds_bus,        eb);
    end
  end

  task automatic cyc(input bit v, input logic [31:0] pc, input bit dsa, input bit fl);
    @(posedge clk); #1;
    fs2ds_valid = v;
    fs2ds_bus   = v ? mk(pc) : '0;
    ds_allowin  = dsa;
    flush       = fl;
    @(negedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    check("rst_count",   64'(iq_count),    64'd0);
    check("rst_valid",   64'(iq2ds_valid), 64'd0);
    check("rst_allowin", 64'(iq_allowin),  64'd1);
    check("rst_bus",     iq2ds_bus,        64'd0);
    @(negedge clk); #2;
    resetn = 1'b1;
    cmp_en = 1'b1;

    // Fill with decode stalled
    cyc(1, 32'h1C000000, 0, 0);
    cyc(1, 32'h1C000004, 0, 0);
    cyc(1, 32'h1C000008, 0, 0);
    cyc(1, 32'h1C00000C, 0, 0);
    cyc(1, 32'h1C000010, 0, 0);
    check("fill_count",   64'(iq_count),   64'd4);
    check("fill_allowin", 64'(iq_allowin), 64'd0);
    check("fill_head",    64'(iq2ds_bus[31:0]), 64'h1C000000);
    cyc(1, 32'h1C000010, 0, 0);
    check("fifth_rejected", 64'(iq_count), 64'd4);

    // Drain across the wrap while refilling
    cyc(1, 32'h1C000010, 1, 0);
    check("drain0", 64'(iq2ds_bus[31:0]), 64'h1C000000);
    cyc(1, 32'h1C000010, 1, 0);
    check("drain1", 64'(iq2ds_bus[31:0]), 64'h1C000004);
    check("drain1_count", 64'(iq_count), 64'd3);
    cyc(1, 32'h1C000014, 1, 0);
    check("drain2", 64'(iq2ds_bus[31:0]), 64'h1C000008);
    cyc(0, 32'h0, 1, 0);
    check("drain3", 64'(iq2ds_bus[31:0]), 64'h1C00000C);

    // Simultaneous push/pop at count 2
    cyc(1, 32'h1C000018, 1, 0);
    check("pp_count", 64'(iq_count), 64'd2);
    check("drain4",   64'(iq2ds_bus[31:0]), 64'h1C000010);
    cyc(0, 32'h0, 0, 0);
    check("pp_count_after", 64'(iq_count), 64'd2);
    check("drain5",         64'(iq2ds_bus[31:0]), 64'h1C000014);

    // Flush at count 3 with an inbound bundle
    cyc(1, 32'h1C00001C, 0, 0);
    cyc(1, 32'h1C000020, 1, 1);
    check("pre_flush_count", 64'(iq_count), 64'd3);
    cyc(0, 32'h0, 0, 0);
    check("flush_count",   64'(iq_count),    64'd0);
    check("flush_valid",   64'(iq2ds_valid), 64'd0);
    check("flush_allowin", 64'(iq_allowin),  64'd1);
    cyc(1, 32'h1C008000, 0, 0);
    cyc(0, 32'h0, 1, 0);
    check("post_flush_first", 64'(iq2ds_bus[31:0]), 64'h1C008000);
    cyc(0, 32'h0, 0, 0);
    check("post_flush_empty", 64'(iq_count), 64'd0);

    // Empty queue, decode ready
    cyc(1, 32'h1C000040, 1, 0);
    check("byp_valid0", 64'(iq2ds_valid), 64'(BYP));
    check("byp_count0", 64'(iq_count),    64'd0);
    if (BYP) check("byp_bus0", 64'(iq2ds_bus[31:0]), 64'h1C000040);
    cyc(0, 32'h0, 1, 0);
    check("byp_valid1", 64'(iq2ds_valid), 64'(!BYP));
    check("byp_count1", 64'(iq_count),    64'(!BYP));
    if (!BYP) check("byp_bus1", 64'(iq2ds_bus[31:0]), 64'h1C000040);
    cyc(0, 32'h0, 0, 0);

    // Asynchronous reset mid-run at count 3
    cyc(1, 32'h1C000050, 0, 0);
    cyc(1, 32'h1C000054, 0, 0);
    cyc(1, 32'h1C000058, 0, 0);
    cyc(0, 32'h0, 0, 0);
    check("pre_rst_count", 64'(iq_count), 64'd3);
    resetn = 1'b0;
    #1;
    check("arst_count",   64'(iq_count),    64'd0);
    check("arst_valid",   64'(iq2ds_valid), 64'd0);
    check("arst_allowin", 64'(iq_allowin),  64'd1);
    @(negedge clk); #2;
    resetn = 1'b1;
    cyc(1, 32'h1C000060, 0, 0);
    cyc(0, 32'h0, 0, 0);
    check("post_rst_head", 64'(iq2ds_bus[31:0]), 64'h1C000060);
    cyc(0, 32'h0, 1, 0);
    cyc(0, 32'h0, 0, 0);
    cmp_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
